seq_frame_sync_ctrl: RTL and testbench

Framing controller that schedules the bit-serial sync-pattern detector over a continuous serial stream. It hunts for a programmable sync word, confirms it at the frame period, and declares lock. While locked it forwards payload bits and counts consecutive sync misses before dropping back to hunt. It sits between the serial receive front end and the payload deframer.

---
 rtl/seq_frame_sync_pkg.sv | 12 +
 rtl/seq_pattern_window.sv | 46 ++++
 rtl/seq_frame_sync_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_seq_frame_sync_ctrl.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_frame_sync_pkg.sv
// Shared types for the serial frame-sync controller.
package seq_frame_sync_pkg;

   localparam int FS_STATE_W = 2;

   typedef enum logic [FS_STATE_W-1:0] {
      FS_HUNT    = 2'd0,
      FS_CONFIRM = 2'd1,
      FS_LOCKED  = 2'd2
   } fs_state_t;

endpackage

// File: rtl/seq_pattern_window.sv
// Sliding sync-word window: remembers the last PAT_W-1 valid bits and
// compares them, together with the incoming bit, against the sync word.
// The oldest bit of the full PAT_W window is only ever needed on the cycle
// it is compared, so it is taken from the history plus the live bit.
module seq_pattern_window
   import seq_frame_sync_pkg::*;
#(
   parameter int PAT_W = 4
) (
   input  logic             clk,
   input  logic             i_clr,
   input  logic             i_valid,
   input  logic             i_bit,
   input  logic [PAT_W-1:0] i_pat,
   output logic             o_match
);

   localparam int FILL_W = (PAT_W > 2) ? $clog2(PAT_W) : 1;
   localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(PAT_W - 1);
   localparam logic [FILL_W-1:0] FILL_ZERO = {FILL_W{1'b0}};
   localparam logic [FILL_W-1:0] FILL_ONE  = FILL_W'(1);

   logic [PAT_W-2:0] r_hist;
   logic [FILL_W-1:0] r_fill;
   logic [PAT_W-1:0] w_cand;
   logic             w_full;

   assign w_cand  = {r_hist, i_bit};
   assign w_full  = (r_fill == FILL_LAST);
   assign o_match = i_valid & w_full & (w_cand == i_pat);

   // Shift valid bits into the history and count fill up to PAT_W-1 stored bits.
   always_ff @(posedge clk) begin
      if (i_clr) begin
         r_hist <= {(PAT_W-1){1'b0}};
         r_fill <= FILL_ZERO;
      end else if (i_valid) begin
         r_hist <= w_cand[PAT_W-2:0];
         r_fill <= w_full ? r_fill : (r_fill + FILL_ONE);
      end else begin
         r_hist <= r_hist;
         r_fill <= r_fill;
      end
   end

endmodule

// File: rtl/seq_frame_sync_ctrl.sv
// Frame-sync controller: hunts for the sync word, confirms it at the frame
// period, holds lock while forwarding payload bits, and drops lock after
// MISS_CNT consecutive missed syncs.
module seq_frame_sync_ctrl
   import seq_frame_sync_pkg::*;
#(
   parameter int PAT_W     = 4,
   parameter int FRAME_LEN = 16,
   parameter int LOCK_CNT  = 2,
   parameter int MISS_CNT  = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  enable,
   input  logic [PAT_W-1:0]      sync_pattern,
   input  logic                  din_valid,
   input  logic                  din,
   output logic                  locked,
   output logic                  frame_start,
   output logic                  sync_err,
   output logic                  payload_valid,
   output logic                  payload_bit,
   output logic [FS_STATE_W-1:0] fs_state
);

   localparam int CNT_W  = $clog2(FRAME_LEN);
   localparam int GOOD_W = (LOCK_CNT > 1) ? $clog2(LOCK_CNT + 1) : 1;
   localparam int MISS_W = (MISS_CNT > 1) ? $clog2(MISS_CNT + 1) : 1;

   localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0]  CHK_POS   = CNT_W'(FRAME_LEN - 1);
   localparam logic [CNT_W-1:0]  PAY_LAST  = CNT_W'(FRAME_LEN - PAT_W - 1);
   localparam logic [GOOD_W-1:0] GOOD_ZERO = {GOOD_W{1'b0}};
   localparam logic [GOOD_W-1:0] GOOD_ONE  = GOOD_W'(1);
   localparam logic [GOOD_W-1:0] GOOD_LOCK = GOOD_W'(LOCK_CNT);
   localparam logic [MISS_W-1:0] MISS_ZERO = {MISS_W{1'b0}};
   localparam logic [MISS_W-1:0] MISS_ONE  = MISS_W'(1);
   localparam logic [MISS_W-1:0] MISS_DROP = MISS_W'(MISS_CNT);

   logic [PAT_W-1:0]  r_pat_q;
   fs_state_t         r_state;
   logic [CNT_W-1:0]  r_bit_cnt;
   logic [GOOD_W-1:0] r_good;
   logic [MISS_W-1:0] r_miss;
   logic              r_locked;
   logic              r_frame_start;
   logic              r_sync_err;
   logic              r_payload_valid;
   logic              r_payload_bit;

   logic              w_clr;
   logic              w_match;
   logic              w_at_chk;
   logic              w_is_payload;
   logic [CNT_W-1:0]  w_bit_cnt_adv;
   logic [GOOD_W-1:0] w_good_inc;
   logic [MISS_W-1:0] w_miss_inc;
   fs_state_t         w_state_nxt;
   logic [CNT_W-1:0]  w_bit_cnt_nxt;
   logic [GOOD_W-1:0] w_good_nxt;
   logic [MISS_W-1:0] w_miss_nxt;
   logic              w_frame_start_nxt;
   logic              w_sync_err_nxt;
   logic              w_payload_valid_nxt;
   logic              w_payload_bit_nxt;

   assign w_clr         = reset | ~enable;
   assign w_at_chk      = (r_bit_cnt == CHK_POS);
   assign w_is_payload  = (r_bit_cnt <= PAY_LAST);
   assign w_bit_cnt_adv = w_at_chk ? CNT_ZERO : (r_bit_cnt + CNT_ONE);
   assign w_good_inc    = r_good + GOOD_ONE;
   assign w_miss_inc    = r_miss + MISS_ONE;

   seq_pattern_window #(
      .PAT_W (PAT_W)
   ) u_window (
      .clk     (clk),
      .i_clr   (w_clr),
      .i_valid (din_valid),
      .i_bit   (din),
      .i_pat   (r_pat_q),
      .o_match (w_match)
   );

   // Capture the sync word whenever the block is held in reset or disabled.
   always_ff @(posedge clk) begin
      if (reset || !enable) begin
         r_pat_q <= sync_pattern;
      end else begin
         r_pat_q <= r_pat_q;
      end
   end

   // Next-state, counter and output-pulse decode; idle cycles hold everything.
   always_comb begin
      w_state_nxt         = r_state;
      w_bit_cnt_nxt       = r_bit_cnt;
      w_good_nxt          = r_good;
      w_miss_nxt          = r_miss;
      w_frame_start_nxt   = 1'b0;
      w_sync_err_nxt      = 1'b0;
      w_payload_valid_nxt = 1'b0;
      w_payload_bit_nxt   = 1'b0;
      if (din_valid) begin
         w_bit_cnt_nxt = w_bit_cnt_adv;
         case (r_state)
            FS_HUNT: begin
               if (w_match) begin
                  w_bit_cnt_nxt = CNT_ZERO;
                  w_good_nxt    = GOOD_ONE;
                  if (LOCK_CNT == 1) begin
                     w_state_nxt       = FS_LOCKED;
                     w_frame_start_nxt = 1'b1;
                     w_miss_nxt        = MISS_ZERO;
                  end else begin
                     w_state_nxt = FS_CONFIRM;
                  end
               end else begin
                  w_state_nxt = FS_HUNT;
               end
            end
            FS_CONFIRM: begin
               if (!w_at_chk) begin
                  w_state_nxt = FS_CONFIRM;
               end else if (w_match) begin
                  w_good_nxt = w_good_inc;
                  if (w_good_inc == GOOD_LOCK) begin
                     w_state_nxt       = FS_LOCKED;
                     w_frame_start_nxt = 1'b1;
                     w_miss_nxt        = MISS_ZERO;
                  end else begin
                     w_state_nxt = FS_CONFIRM;
                  end
               end else begin
                  // Window is kept; the current bit is not re-hunted.
                  w_state_nxt = FS_HUNT;
               end
            end
            FS_LOCKED: begin
               if (w_is_payload) begin
                  w_payload_valid_nxt = 1'b1;
                  w_payload_bit_nxt   = din;
               end else begin
                  w_payload_valid_nxt = 1'b0;
               end
               if (!w_at_chk) begin
                  w_state_nxt = FS_LOCKED;
               end else if (w_match) begin
                  w_miss_nxt        = MISS_ZERO;
                  w_frame_start_nxt = 1'b1;
               end else begin
                  w_miss_nxt     = w_miss_inc;
                  w_sync_err_nxt = 1'b1;
                  if (w_miss_inc == MISS_DROP) begin
                     w_state_nxt = FS_HUNT;
                  end else begin
                     w_state_nxt = FS_LOCKED;
                  end
               end
            end
            default: begin
               w_state_nxt = FS_HUNT;
            end
         endcase
      end else begin
         w_state_nxt = r_state;
      end
   end

   // State, counters and registered outputs; reset beats enable, enable beats data.
   always_ff @(posedge clk) begin
      if (reset || !enable) begin
         r_state         <= FS_HUNT;
         r_bit_cnt       <= CNT_ZERO;
         r_good          <= GOOD_ZERO;
         r_miss          <= MISS_ZERO;
         r_locked        <= 1'b0;
         r_frame_start   <= 1'b0;
         r_sync_err      <= 1'b0;
         r_payload_valid <= 1'b0;
         r_payload_bit   <= 1'b0;
      end else begin
         r_state         <= w_state_nxt;
         r_bit_cnt       <= w_bit_cnt_nxt;
         r_good          <= w_good_nxt;
         r_miss          <= w_miss_nxt;
         r_locked        <= (w_state_nxt == FS_LOCKED);
         r_frame_start   <= w_frame_start_nxt;
         r_sync_err      <= w_sync_err_nxt;
         r_payload_valid <= w_payload_valid_nxt;
         r_payload_bit   <= w_payload_bit_nxt;
      end
   end

   assign locked        = r_locked;
   assign frame_start   = r_frame_start;
   assign sync_err      = r_sync_err;
   assign payload_valid = r_payload_valid;
   assign payload_bit   = r_payload_bit;
   assign fs_state      = r_state;

endmodule

// File: tb/tb_seq_frame_sync_ctrl.sv
// Scoreboard bench for seq_frame_sync_ctrl: a reference model built from
// the framing rules predicts every output pulse; a monitor pops and compares.
module tb_seq_frame_sync_ctrl;

   localparam int PAT_W = 4;
   localparam int FL    = 8;
   localparam int LOCK  = 2;
   localparam int MISS  = 2;

   logic             clk = 1'b0;
   logic             reset;
   logic             enable;
   logic [PAT_W-1:0] sync_pattern;
   logic             din_valid;
   logic             din;
   logic             locked;
   logic             frame_start;
   logic             sync_err;
   logic             payload_valid;
   logic             payload_bit;
   logic [1:0]       fs_state;

   typedef struct packed {
      logic       fs;
      logic       se;
      logic       pv;
      logic       pb;
      logic       lk;
      logic [1:0] st;
   } ev_t;

   ev_t exp_q[$];
   ev_t mon_e;
   int  checks = 0;
   int  errors = 0;

   // reference model state
   int         m_st   = 0;
   int         m_pos  = 0;
   int         m_good = 0;
   int         m_miss = 0;
   bit         m_hist[$];
   logic [3:0] m_pat  = 4'b0000;
   logic [1:0] exp_st = 2'd0;
   logic       exp_lk = 1'b0;

   seq_frame_sync_ctrl #(
      .PAT_W     (PAT_W),
      .FRAME_LEN (FL),
      .LOCK_CNT  (LOCK),
      .MISS_CNT  (MISS)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .enable        (enable),
      .sync_pattern  (sync_pattern),
      .din_valid     (din_valid),
      .din           (din),
      .locked        (locked),
      .frame_start   (frame_start),
      .sync_err      (sync_err),
      .payload_valid (payload_valid),
      .payload_bit   (payload_bit),
      .fs_state      (fs_state)
   );

   always #5 clk = ~clk;

   function automatic bit rbit();
      return bit'($urandom() & 32'd1);
   endfunction

   function automatic bit hist_matches();
      if (m_hist.size() != PAT_W) return 1'b0;
      for (int i = 0; i < PAT_W; i++) begin
         if (m_hist[i] != m_pat[PAT_W-1-i]) return 1'b0;
      end
      return 1'b1;
   endfunction

   // Reference model: one call per clock edge, pushes the pulses it predicts.
   task automatic model_step(input bit rst, input bit en, input bit v, input bit b);
      ev_t e;
      bit  m;
      bit  at;
      e = '0;
      if (rst || !en) begin
         m_st = 0; m_pos = 0; m_good = 0; m_miss = 0;
         m_hist.delete();
         m_pat = sync_pattern;
      end else if (v) begin
         m_hist.push_back(b);
         if (m_hist.size() > PAT_W) void'(m_hist.pop_front());
         m  = hist_matches();
         at = (m_pos == FL - 1);
         if (m_st == 0) begin
            m_pos = (m_pos + 1) % FL;
            if (m) begin
               m_pos = 0; m_good = 1;
               if (LOCK == 1) begin m_st = 2; e.fs = 1'b1; m_miss = 0; end
               else m_st = 1;
            end
         end else if (m_st == 1) begin
            m_pos = (m_pos + 1) % FL;
            if (at) begin
               if (m) begin
                  m_good++;
                  if (m_good == LOCK) begin m_st = 2; e.fs = 1'b1; m_miss = 0; end
               end else begin
                  m_st = 0;
               end
            end
         end else begin
            if (m_pos < FL - PAT_W) begin e.pv = 1'b1; e.pb = b; end
            m_pos = (m_pos + 1) % FL;
            if (at) begin
               if (m) begin m_miss = 0; e.fs = 1'b1; end
               else begin
                  m_miss++; e.se = 1'b1;
                  if (m_miss == MISS) m_st = 0;
               end
            end
         end
         e.lk = (m_st == 2);
         e.st = 2'(m_st);
         if (e.fs || e.se || e.pv) exp_q.push_back(e);
      end
      exp_st = 2'(m_st);
      exp_lk = (m_st == 2);
   endtask

   // Monitor: every pulse the DUT presents must match the next predicted event.
   always @(negedge clk) begin
      if (frame_start || sync_err || payload_valid) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL pulse_unexpected got fs=%0b se=%0b pv=%0b st=%0d required no pulse",
                     frame_start, sync_err, payload_valid, fs_state);
         end else begin
            mon_e = exp_q.pop_front();
            if (frame_start !== mon_e.fs || sync_err !== mon_e.se || payload_valid !== mon_e.pv ||
                locked !== mon_e.lk || fs_state !== mon_e.st || (mon_e.pv && payload_bit !== mon_e.pb)) begin
               errors++;
               $display("FAIL pulse_event got fs=%0b se=%0b pv=%0b pb=%0b lk=%0b st=%0d required fs=%0b se=%0b pv=%0b pb=%0b lk=%0b st=%0d",
                        frame_start, sync_err, payload_valid, payload_bit, locked, fs_state,
                        mon_e.fs, mon_e.se, mon_e.pv, mon_e.pb, mon_e.lk, mon_e.st);
            end
         end
      end
   end

   // One clock: check state left by the previous edge, then drive and predict.
   task automatic step(input bit rst, input bit en, input bit v, input bit b);
      @(negedge clk);
      checks++;
      if (fs_state !== exp_st || locked !== exp_lk) begin
         errors++;
         $display("FAIL state got st=%0d lk=%0b required st=%0d lk=%0b", fs_state, locked, exp_st, exp_lk);
      end
      reset     = rst;
      enable    = en;
      din_valid = v;
      din       = b;
      model_step(rst, en, v, b);
   endtask

   task automatic send_bits(input logic [63:0] bits, input int n, input int max_gap);
      for (int i = n - 1; i >= 0; i--) begin
         automatic int g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
         for (int k = 0; k < g; k++) step(1'b0, 1'b1, 1'b0, rbit());
         step(1'b0, 1'b1, 1'b1, bits[i]);
      end
   endtask

   task automatic drain();
      repeat (3) step(1'b0, 1'b1, 1'b0, rbit());
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain got %0d pending events required 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic soft_reset();
      repeat (2) step(1'b0, 1'b0, 1'b1, rbit());
   endtask

   logic [63:0] acq_bits;
   logic [63:0] miss_bits;
   logic [63:0] frame;

   initial begin
      reset        = 1'b1;
      enable       = 1'b1;
      din_valid    = 1'b0;
      din          = 1'b0;
      sync_pattern = 4'b1011;
      acq_bits     = 64'h0000_0000_0000_B6B3;
      miss_bits    = 64'h0000_0B6B_395B_69C0;

      // reset held three cycles with random data
      repeat (3) step(1'b1, 1'b1, rbit(), rbit());
      step(1'b0, 1'b1, 1'b0, 1'b0);
      checks++;
      if ({frame_start, sync_err, payload_valid, payload_bit, locked, fs_state} !== 7'd0) begin
         errors++;
         $display("FAIL reset_outputs got %b required 0000000",
                  {frame_start, sync_err, payload_valid, payload_bit, locked, fs_state});
      end

      // acquire: 1011 0110 1011 0011
      send_bits(acq_bits, 16, 0);
      drain();

      // false sync in the second slot
      soft_reset();
      send_bits(64'h0000_0000_0000_B090, 16, 0);
      drain();

      // miss handling: single miss, recovery, then two misses drop lock
      step(1'b1, 1'b1, 1'b0, 1'b0);
      send_bits(miss_bits, 44, 0);
      drain();

      // acquire with random idle gaps, twice
      for (int r = 0; r < 2; r++) begin
         soft_reset();
         send_bits(acq_bits, 16, 3);
         drain();
      end

      // reset mid-payload, then full reacquisition
      soft_reset();
      send_bits(64'h0000_0000_0000_2DAC >> 0, 14, 0);
      step(1'b1, 1'b1, 1'b1, 1'b1);
      send_bits(acq_bits, 16, 0);
      drain();

      // enable drop mid-payload, then full reacquisition
      soft_reset();
      send_bits(64'h0000_0000_0000_2DAC, 14, 0);
      step(1'b0, 1'b0, 1'b1, 1'b0);
      send_bits(acq_bits, 16, 1);
      drain();

      // randomized frames: random offset, mostly good syncs, random gaps
      for (int r = 0; r < 3; r++) begin
         soft_reset();
         send_bits(64'($urandom()), int'($urandom_range(7, 0)), 0);
         for (int f = 0; f < 40; f++) begin
            frame = 64'($urandom_range(15, 0));
            frame = frame << 4;
            if ($urandom_range(4, 0) != 0) frame = frame | 64'h0B;
            else frame = frame | 64'($urandom_range(15, 0));
            send_bits(frame, 8, 2);
         end
         drain();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
